// File: rtl/median_sort_sequencer.sv
// median_sort_sequencer: collects a WIN_SIZE pixel window serially, sorts it
// in place by odd-even transposition using one shared comparator (one
// compare-swap per clock), then presents z_min / z_med / z_max.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   clear               synchronous abort back to LOAD
//   in_valid/in_ready   sample handshake, in_data in raster order
//   out_valid/out_ready result handshake for z_min, z_med, z_max
//   busy                high while sorting

// comparator: y = 1 when b is strictly greater than a.
module comparator #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic                  y
);
    assign y = (b > a);
endmodule

module median_sort_sequencer #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned WIN_SIZE   = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] z_min,
    output logic [DATA_WIDTH-1:0] z_med,
    output logic [DATA_WIDTH-1:0] z_max,
    output logic                  busy
);

    localparam int unsigned NPAIR  = (WIN_SIZE - 1) / 2;
    localparam int unsigned MED    = (WIN_SIZE - 1) / 2;
    localparam int unsigned IDX_W  = $clog2(WIN_SIZE);
    localparam int unsigned PAIR_W = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WIN_SIZE - 1);
    localparam logic [PAIR_W-1:0] LAST_PAIR = PAIR_W'(NPAIR - 1);

    generate
        if ((WIN_SIZE % 2 == 0) || (WIN_SIZE < 3) || (WIN_SIZE > 25)) begin : g_bad_win
            $error("median_sort_sequencer: WIN_SIZE must be odd and in 3..25");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_LOAD = 2'd0,
        S_SORT = 2'd1,
        S_OUT  = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [IDX_W-1:0]      count_q, count_d;
    logic [IDX_W-1:0]      pass_q,  pass_d;
    logic [PAIR_W-1:0]     pair_q,  pair_d;
    logic [DATA_WIDTH-1:0] buf_q [WIN_SIZE];
    logic [DATA_WIDTH-1:0] buf_d [WIN_SIZE];

    logic [IDX_W-1:0]      idx, idx_p1;
    logic [DATA_WIDTH-1:0] cmp_a, cmp_b;
    logic                  cmp_y;

    // Lower index of the active pair: even passes start at 0, odd passes at 1.
    assign idx    = IDX_W'({pair_q, 1'b0}) | IDX_W'(pass_q[0]);
    assign idx_p1 = idx + IDX_W'(1);

    // Operand select for the shared comparator.
    always_comb begin
        cmp_a = '0;
        cmp_b = '0;
        for (int j = 0; j < WIN_SIZE; j++) begin
            if (IDX_W'(j) == idx)    cmp_b = buf_q[j];
            if (IDX_W'(j) == idx_p1) cmp_a = buf_q[j];
        end
    end

    comparator #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
        .a (cmp_a),
        .b (cmp_b),
        .y (cmp_y)
    );

    // Next-state, counter and buffer update.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        pass_d  = pass_q;
        pair_d  = pair_q;
        buf_d   = buf_q;

        case (state_q)
            S_LOAD: begin
                if (in_valid) begin
                    for (int j = 0; j < WIN_SIZE; j++) begin
                        if (IDX_W'(j) == count_q) buf_d[j] = in_data;
                    end
                    if (count_q == LAST_IDX) begin
                        count_d = '0;
                        state_d = S_SORT;
                    end else begin
                        count_d = count_q + IDX_W'(1);
                    end
                end
            end
            S_SORT: begin
                // Strict compare: equal neighbours stay in place.
                if (cmp_y) begin
                    for (int j = 0; j < WIN_SIZE; j++) begin
                        if (IDX_W'(j) == idx)    buf_d[j] = cmp_a;
                        if (IDX_W'(j) == idx_p1) buf_d[j] = cmp_b;
                    end
                end
                if (pair_q == LAST_PAIR) begin
                    pair_d = '0;
                    if (pass_q == LAST_IDX) begin
                        pass_d  = '0;
                        state_d = S_OUT;
                    end else begin
                        pass_d = pass_q + IDX_W'(1);
                    end
                end else begin
                    pair_d = pair_q + PAIR_W'(1);
                end
            end
            S_OUT: begin
                if (out_ready) state_d = S_LOAD;
            end
            default: state_d = S_LOAD;
        endcase

        // Abort discards any sample or result handshake in the same cycle.
        if (clear) begin
            state_d = S_LOAD;
            count_d = '0;
            pass_d  = '0;
            pair_d  = '0;
            buf_d   = buf_q;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LOAD;
            count_q <= '0;
            pass_q  <= '0;
            pair_q  <= '0;
            for (int j = 0; j < WIN_SIZE; j++) buf_q[j] <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            pass_q  <= pass_d;
            pair_q  <= pair_d;
            for (int j = 0; j < WIN_SIZE; j++) buf_q[j] <= buf_d[j];
        end
    end

    assign in_ready  = (state_q == S_LOAD);
    assign busy      = (state_q == S_SORT);
    assign out_valid = (state_q == S_OUT);
    assign z_min     = buf_q[0];
    assign z_med     = buf_q[MED];
    assign z_max     = buf_q[WIN_SIZE-1];

endmodule

// File: tb/tb_median_sort_sequencer.sv
// Scoreboard bench for median_sort_sequencer (DATA_WIDTH=8, WIN_SIZE=9).
module tb_median_sort_sequencer;

    localparam int unsigned DW = 8;
    localparam int unsigned WS = 9;

    typedef logic [DW-1:0] win_t [WS];

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] z_min, z_med, z_max;
    logic          busy;

    int checks = 0;
    int errors = 0;
    int ycount = 0;
    logic [23:0] sb_q [$];

    median_sort_sequencer #(.DATA_WIDTH(DW), .WIN_SIZE(WS)) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z_min     (z_min),
        .z_med     (z_med),
        .z_max     (z_max),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every completed result handshake.
    always @(negedge clk) begin
        logic [23:0] e;
        if (!rst && !clear && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result actual=%0h required=none", {z_min, z_med, z_max});
            end else begin
                e = sb_q.pop_front();
                chk("result", {8'h0, z_min, z_med, z_max}, {8'h0, e});
            end
        end
    end

    // Comparator activity during sorting.
    always @(negedge clk) begin
        if (!rst && busy && dut.cmp_y) ycount++;
    end

    task automatic send(input logic [DW-1:0] d);
        int t;
        t = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) chk("ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic load_win(input win_t w);
        for (int k = 0; k < WS; k++) send(w[k]);
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) chk("out_valid_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        win_t w;
        int   n;

        // Reset values
        @(posedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_z", {8'h0, z_min, z_med, z_max}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_in_ready", 32'(in_ready), 1);

        // Ascending window, latency and busy
        sb_q.push_back({8'd1, 8'd5, 8'd9});
        w = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
        load_win(w);
        n = 1;
        @(negedge clk);
        chk("busy_sort", 32'(busy), 1);
        chk("in_ready_sort", 32'(in_ready), 0);
        while (!out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("latency", n, 37);
        @(posedge clk); #1;

        // Descending window: every compare swaps
        ycount = 0;
        sb_q.push_back({8'd1, 8'd5, 8'd9});
        w = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        load_win(w);
        wait_out();
        chk("desc_swaps", ycount, 36);
        @(posedge clk); #1;

        // Alternating extremes: sorted 0,0,0,0,128,255,255,255,255
        sb_q.push_back({8'd0, 8'd128, 8'd255});
        w = '{8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd0, 8'd255, 8'd128};
        load_win(w);
        wait_out();
        @(posedge clk); #1;

        // All equal: no swaps
        ycount = 0;
        sb_q.push_back({8'h7F, 8'h7F, 8'h7F});
        for (int k = 0; k < WS; k++) w[k] = 8'h7F;
        load_win(w);
        wait_out();
        chk("equal_no_swaps", ycount, 0);
        @(posedge clk); #1;

        // Backpressure: result held while out_ready is low
        out_ready = 1'b0;
        sb_q.push_back({8'd1, 8'd4, 8'd9});
        w = '{8'd3, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6, 8'd5};
        load_win(w);
        wait_out();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("hold_valid", 32'(out_valid), 1);
            chk("hold_in_ready", 32'(in_ready), 0);
            chk("hold_z", {8'h0, z_min, z_med, z_max}, {8'h0, 8'd1, 8'd4, 8'd9});
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("release_in_ready", 32'(in_ready), 1);
        chk("release_out_valid", 32'(out_valid), 0);
        @(posedge clk); #1;

        // Clear during sort cycle 20
        w = '{8'd200, 8'd100, 8'd50, 8'd25, 8'd12, 8'd6, 8'd3, 8'd1, 8'd0};
        load_win(w);
        repeat (19) @(posedge clk);
        #1;
        chk("pre_clear_busy", 32'(busy), 1);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        chk("clear_busy", 32'(busy), 0);
        chk("clear_in_ready", 32'(in_ready), 1);
        @(posedge clk); #1;
        sb_q.push_back({8'd1, 8'd5, 8'd9});
        w = '{8'd5, 8'd5, 8'd5, 8'd1, 8'd1, 8'd1, 8'd9, 8'd9, 8'd9};
        load_win(w);
        wait_out();
        @(posedge clk); #1;

        // Reset after 4 samples of a partial window
        for (int k = 0; k < 4; k++) send(8'd250);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_z", {8'h0, z_min, z_med, z_max}, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midrst_in_ready", 32'(in_ready), 1);
        sb_q.push_back({8'd10, 8'd50, 8'd90});
        w = '{8'd50, 8'd10, 8'd40, 8'd20, 8'd30, 8'd90, 8'd70, 8'd60, 8'd80};
        load_win(w);
        wait_out();
        @(posedge clk); #1;

        repeat (3) @(posedge clk);
        chk("sb_empty", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
